fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single FIFO write port among `N_REQ` producers. It sits between the producers and the FIFO controller's `we` / data inputs, and uses the controller's `fifo_full` flag as backpressure. Each granted producer keeps the port for a burst of up to `MAX_BURST` accepted beats, then the grant rotates. Ownership is therefore fair and bounded, and no write is ever issued into a full FIFO.

## Interface
- `N_REQ`, default 4: number of producers, 2..8.
- `DATA_W`, default 8: FIFO data width.
- `MAX_BURST`, default 4: maximum beats accepted per grant, 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in `N_REQ`: producer i requests the write port; held high while it has data.
- `req_data` in `N_REQ*DATA_W`: producer i data at bits `[i*DATA_W +: DATA_W]`.
- `fifo_full` in 1: full flag from the FIFO controller.
- `gnt` out `N_REQ`: registered one-hot grant, or all zeros.
- `ack` out `N_REQ`: combinational; bit i high when producer i's beat is written this cycle.
- `fifo_we` out 1: combinational write enable to the FIFO controller.
- `fifo_wdata` out `DATA_W`: data of the granted producer; zero when there is no grant.
- `busy` out 1: registered; high in BURST.

## Operation
- **Two-state FSM:**
  - IDLE: `gnt` is 0.
  - BURST: exactly one `gnt` bit is set (the owner `o`).
- **Registered state:**
  - `state`
  - `gnt`
  - `last` (index of the most recent winner, `clog2(N_REQ)` bits)
  - `beat_cnt` (8 bits)
- **IDLE:**
  - If `req` is 0, stay in IDLE.
  - Otherwise the winner is the first set `req` bit searching `last+1, last+2, ...` modulo `N_REQ`.
  - Next edge: `gnt` is set to the winner's one-hot, `last` takes the winner index, `beat_cnt` is cleared to 0, and the FSM moves to BURST.
- **BURST:**
  - `accept = req[o] & ~fifo_full`.
  - `fifo_we = accept`, `ack[o] = accept`.
  - `fifo_wdata = req_data[o]`, driven even when `accept` is 0.
- **BURST on an accepted beat:**
  - `beat_cnt` increments.
  - If `beat_cnt == MAX_BURST-1`, this is the last beat: next state is IDLE and `gnt` is cleared.
- **BURST exit when `req[o]` is low:** next state is IDLE, with no write that cycle.
- **BURST stall:** when `req[o]` is high and `fifo_full` is high, stay in BURST, hold `beat_cnt`, and keep `fifo_we` at 0. There is no timeout.
- **Arbitration gap:** every exit from BURST passes through exactly one IDLE cycle. A bus that is continuously requested therefore carries at most `MAX_BURST` beats per `MAX_BURST+1` cycles.
- **Producer during the IDLE gap:** a producer that drops `req` during IDLE is not granted. It must re-request, and there is no pending memory.
- **`fifo_full` changes:** `fifo_full` is sampled combinationally each cycle. It rising on the same cycle as an otherwise-accepted beat blocks that beat.
- **Grant invariant:** the `gnt` one-hot invariant always holds; `ack` is a subset of `gnt` and has at most one bit set.

## Timing
- **Reset values:**
  - `state` = IDLE
  - `gnt` = 0
  - `busy` = 0
  - `beat_cnt` = 0
  - `last` = `N_REQ-1`, so producer 0 wins first after reset
  - Combinational outputs are therefore `fifo_we` = 0, `ack` = 0, `fifo_wdata` = 0.
- **Latency:** `req` rises at edge-cycle t in IDLE → `gnt` at t+1 → first possible `fifo_we` in cycle t+1.
- **Write capture:** the beat is written at the rising edge that ends the cycle in which `fifo_we` is high. The producer advances its data on the cycle after `ack`.
- **Reset mid-burst:** `rst` sampled high aborts the burst at that edge. Beats already acked are complete; no partial state survives.
- **`rst` with `req` high:** when `rst` and `req` are high at the same time, reset wins. Arbitration resumes on the first edge with `rst` low.

## Structure
- Shared header `fifo_arb_defs.vh` holds:
  - the state encodings `ARB_IDLE = 1'b0`, `ARB_BURST = 1'b1`
  - the burst counter width constant `ARB_CNT_W = 8`.
- One sub-module, `rr_pick`: a combinational rotate-priority-rotate-back selector.
  - Inputs: `req`, `last`.
  - Outputs: `win_onehot`, `win_idx`, `any`.
- The top level holds the FSM, the counter and the output muxing. Target is about 150–250 lines total.

## Test plan
- **Reset:** `rst` high for 2 cycles with `req=4'b1111` → `gnt=0`, `fifo_we=0` throughout; first edge after release gives `gnt=4'b0001`.
- **Full rotation:** `req=4'b1111` held, `fifo_full=0`, `MAX_BURST=4` → owners 0,1,2,3,0. Each owner gets 4 consecutive `fifo_we` cycles followed by 1 IDLE cycle; 20 writes in 25 cycles.
- **Backpressure:** owner 1, `fifo_full` high for 3 cycles after beat 2 → `fifo_we=0` for those 3 cycles, `beat_cnt` holds at 2, burst still delivers exactly 4 beats.
- **Early release:** `req=4'b0101`, `req[0]` drops after 2 acked beats → IDLE for 1 cycle, then `gnt=4'b0100`; `fifo_wdata` equals `req_data[2]` (e.g. `8'hC2`).
- **Data routing:** distinct `req_data` per producer (`8'hA0`–`8'hA3`) → every `fifo_we` cycle carries the granted producer's value, and `ack` matches `gnt`.
- **Reset mid-burst:** `rst` asserted on beat 2 of owner 3 → next cycle `gnt=0`, `last=N_REQ-1`; after release with `req=4'b1000`, owner 3 is granted with `beat_cnt=0`.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter: FSM state
// encodings, burst counter width and an index-width helper.
package fifo_wr_arbiter_pkg;

    // Two-state arbiter FSM: waiting for requests, or serving one owner.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Width of the per-grant beat counter (covers MAX_BURST up to 255).
    localparam int ARB_CNT_W = 8;

    // Bits needed to index n producers; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: rotates the request vector so the
// search starts just after the previous winner, takes the first set bit,
// and maps that position back to an absolute producer index.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    // pos[k] is the absolute producer checked at search priority k.
    logic [IDX_W-1:0] pos [N_REQ];
    logic [N_REQ-1:0] rot;
    logic             found;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign pos[gi] = IDX_W'((int'(last) + 1 + gi) % N_REQ);
            assign rot[gi] = req[pos[gi]];
        end
    endgenerate

    // Priority search over the rotated vector, then rotate the result back.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        any        = |rot;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found   = 1'b1;
                win_idx = pos[k];
            end
        end
        win_onehot[win_idx] = found;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: shares one FIFO write port among N_REQ
// producers, granting bursts of at most MAX_BURST accepted beats and never
// writing while fifo_full is high. Each burst ends with one IDLE cycle.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic                    fifo_full,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic                    fifo_we,
    output logic [DATA_W-1:0]       fifo_wdata,
    output logic                    busy
);

    localparam int IDX_W = idx_w(N_REQ);
    localparam logic [ARB_CNT_W-1:0] LAST_BEAT = ARB_CNT_W'(MAX_BURST - 1);

    arb_state_e           state_q, state_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [ARB_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [N_REQ-1:0]     win_onehot;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;

    // In BURST the owner is always last_q, since last_q records the winner.
    logic                 owner_req;
    logic [DATA_W-1:0]    owner_data;
    logic                 accept;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .last       (last_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any        (win_any)
    );

    assign owner_req  = req[last_q];
    assign owner_data = req_data[int'(last_q)*DATA_W +: DATA_W];

    // Next-state, grant rotation, beat counting and write-port muxing.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        accept     = 1'b0;
        fifo_we    = 1'b0;
        ack        = '0;
        fifo_wdata = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (win_any) begin
                    state_d    = ARB_BURST;
                    gnt_d      = win_onehot;
                    last_d     = win_idx;
                    beat_cnt_d = '0;
                end
            end
            ARB_BURST: begin
                accept     = owner_req & ~fifo_full;
                fifo_we    = accept;
                ack        = accept ? gnt_q : '0;
                fifo_wdata = owner_data;
                if (!owner_req) begin
                    // Owner released early: give up the port, no write.
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + ARB_CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end
                // Owner requesting but FIFO full: stall with count held.
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State register; reset parks last on N_REQ-1 so producer 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q == ARB_BURST);

endmodule
